if_fetch: RTL

//  IF stage of the RV32I pipeline, directly upstream of ID via if_id.
//  - Owns the PC.
//  - Assembles each 32-bit instruction from the byte-wide memory port (4 reads, little-endian).
//  - Presents {pc, inst} to if_id.
//  - Takes branch/jump redirects from ID.
//  - Shares the memory port with MEM through an arbiter grant.

---
 rtl/if_fetch.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// IF stage: owns the PC, assembles 32-bit instructions from a shared byte-wide port, hands {pc, inst} to ID.
// Optional direct-mapped one-word-per-line I-cache enabled by defining ICACHE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_a_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        if_stall_req_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        RD1   = 3'd2,
        RD2   = 3'd3,
        RD3   = 3'd4,
        WAIT3 = 3'd5,
        DONE  = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [23:0] bytes_q, bytes_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic        rdy_prev_q;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] pc_o_q, pc_o_d;
    logic [31:0] inst_o_q, inst_o_d;
    logic        valid_q, valid_d;
    logic [1:0]  rd_idx_s;
    logic        rd0_go_s;
    logic [31:0] rd0_pc_s;
    logic        fill_s;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ICACHE_LINES-1:0] c_valid_q;
    logic [31:0]             c_data_q [ICACHE_LINES];
    logic [TAG_W-1:0]        c_tag_q  [ICACHE_LINES];
    logic [IDX_W-1:0]        look_idx_s;
    logic [IDX_W-1:0]        fill_idx_s;
    logic                    hit_s;

    // Unaligned PCs never hit or fill, so a line always holds an aligned word.
    assign look_idx_s = rd0_pc_s[IDX_W+1:2];
    assign fill_idx_s = pc_q[IDX_W+1:2];
    assign hit_s      = c_valid_q[look_idx_s] && (rd0_pc_s[1:0] == 2'b00)
                        && (c_tag_q[look_idx_s] == rd0_pc_s[31:IDX_W+2]);
`endif

    // Byte offset of the address issued in the current RDk state.
    always_comb begin
        rd_idx_s = 2'd0;
        case (state_q)
            RD1:     rd_idx_s = 2'd1;
            RD2:     rd_idx_s = 2'd2;
            RD3:     rd_idx_s = 2'd3;
            default: rd_idx_s = 2'd0;
        endcase
    end

    // Next-state, capture and output logic; with rdy low every register keeps its value.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bytes_d    = bytes_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        mem_req_d  = mem_req_q;
        mem_a_d    = mem_a_q;
        pc_o_d     = pc_o_q;
        inst_o_d   = inst_o_q;
        valid_d    = valid_q;
        rd0_go_s   = 1'b0;
        rd0_pc_s   = pc_q;
        fill_s     = 1'b0;

        if (rdy) begin
            pend_d = 1'b0;
            if (branch_enable_i) begin
                pc_d     = branch_addr_i;
                bytes_d  = 24'd0;
                valid_d  = 1'b0;
                rd0_go_s = 1'b1;
                rd0_pc_s = branch_addr_i;
            end else if (pend_q && !rdy_prev_q) begin
                // The byte for this issue came back during the freeze: ask for it again.
                mem_req_d = 1'b1;
                mem_a_d   = pc_q + 32'(pend_idx_q);
                case (pend_idx_q)
                    2'd0:    state_d = RD0;
                    2'd1:    state_d = RD1;
                    2'd2:    state_d = RD2;
                    default: state_d = RD3;
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        rd0_go_s = 1'b1;
                        rd0_pc_s = pc_q;
                    end
                    RD0, RD1, RD2, RD3: begin
                        if (pend_q) begin
                            case (pend_idx_q)
                                2'd0:    bytes_d[7:0]   = mem_din_i;
                                2'd1:    bytes_d[15:8]  = mem_din_i;
                                2'd2:    bytes_d[23:16] = mem_din_i;
                                default: bytes_d        = bytes_q;
                            endcase
                        end else begin
                            bytes_d = bytes_q;
                        end
                        if (mem_grant_i) begin
                            pend_d     = 1'b1;
                            pend_idx_d = rd_idx_s;
                            if (state_q == RD3) begin
                                state_d   = WAIT3;
                                mem_req_d = 1'b0;
                            end else begin
                                state_d = state_e'(state_q + 3'd1);
                                mem_a_d = pc_q + 32'(rd_idx_s) + 32'd1;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end
                    WAIT3: begin
                        if (pend_q) begin
                            inst_o_d  = {mem_din_i, bytes_q};
                            pc_o_d    = pc_q;
                            valid_d   = 1'b1;
                            state_d   = DONE;
                            fill_s    = 1'b1;
                        end else begin
                            state_d   = RD3;
                            mem_req_d = 1'b1;
                            mem_a_d   = pc_q + 32'd3;
                        end
                    end
                    DONE: begin
                        if (!stall_i) begin
                            valid_d  = 1'b0;
                            pc_d     = pc_q + 32'd4;
                            rd0_go_s = 1'b1;
                            rd0_pc_s = pc_q + 32'd4;
                        end else begin
                            valid_d  = valid_q;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            if (rd0_go_s) begin
                bytes_d   = 24'd0;
                state_d   = RD0;
                mem_req_d = 1'b1;
                mem_a_d   = rd0_pc_s;
`ifdef ICACHE_EN
                if (hit_s) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    inst_o_d  = c_data_q[look_idx_s];
                    pc_o_d    = rd0_pc_s;
                    valid_d   = 1'b1;
                end else begin
                    state_d   = RD0;
                end
`endif
            end else begin
                mem_a_d = mem_a_d;
            end
        end else begin
            pend_d = pend_q;
        end
    end

    // Pipeline state and registered outputs; rdy_prev tracks rdy so a byte lost to a freeze is detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            bytes_q    <= 24'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            rdy_prev_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_a_q    <= 32'd0;
            pc_o_q     <= 32'd0;
            inst_o_q   <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bytes_q    <= bytes_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            rdy_prev_q <= rdy;
            mem_req_q  <= mem_req_d;
            mem_a_q    <= mem_a_d;
            pc_o_q     <= pc_o_d;
            inst_o_q   <= inst_o_d;
            valid_q    <= valid_d;
        end
    end

`ifdef ICACHE_EN
    // Line valid bits; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid_q <= '0;
        end else if (fill_s && (pc_q[1:0] == 2'b00)) begin
            c_valid_q[fill_idx_s] <= 1'b1;
        end else begin
            c_valid_q <= c_valid_q;
        end
    end

    // Line data and tag, written when a missed word completes.
    always_ff @(posedge clk) begin
        if (fill_s && (pc_q[1:0] == 2'b00)) begin
            c_data_q[fill_idx_s] <= {mem_din_i, bytes_q};
            c_tag_q[fill_idx_s]  <= pc_q[31:IDX_W+2];
        end
    end
`endif

    assign mem_req_o      = mem_req_q;
    assign mem_a_o        = mem_a_q;
    assign pc_o           = pc_o_q;
    assign inst_o         = inst_o_q;
    assign inst_valid_o   = valid_q;
    assign if_stall_req_o = (state_q != DONE) && !rst;

endmodule
